motor_cmd_tx: RTL

//  Controller-side framer for the RC car motor command link; drives the byte bus that MotorControl samples.

---
 rtl/motor_cmd_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/motor_cmd_tx.sv
// rtl/motor_cmd_tx.sv - RC car motor command framer: SYNC, M1, M2, CHECKSUM byte frames with gap
module motor_cmd_tx #(
    parameter int         HOLD_CYCLES = 10,
    parameter int         GAP_CYCLES  = 10,
    parameter logic [7:0] SYNC_BYTE   = 8'h80
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       cmd_valid_in,
    output logic       cmd_ready_out,
    input  logic       m1_dir_in,
    input  logic [7:0] m1_speed_in,
    input  logic       m2_dir_in,
    input  logic [7:0] m2_speed_in,
    output logic [7:0] byte_out,
    output logic       byte_strobe_out,
    output logic       frame_done_out
);

    // The hold counter must cover the longer of the byte hold and the gap.
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // The counter counts down to zero and is reloaded on every state change,
    // so it never wraps.
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_M1,
        ST_M2,
        ST_CS,
        ST_GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic [7:0]    p1_q;
    logic [7:0]    p2_q;
    logic [7:0]    cs_q;

    logic [7:0]    p1_in;
    logic [7:0]    p2_in;
    logic          transfer;
    logic          last_cycle;
    logic          unused_speed_lsbs;

    // Payload bytes keep MSB=0 so SYNC_BYTE (MSB=1) stays unique on the bus;
    // speed is truncated to its top six bits.
    assign p1_in      = {1'b0, m1_dir_in, m1_speed_in[7:2]};
    assign p2_in      = {1'b0, m2_dir_in, m2_speed_in[7:2]};
    assign transfer   = cmd_valid_in & cmd_ready_out;
    assign last_cycle = (hold_cnt == '0);

    // The two speed LSBs are dropped by the truncation.
    assign unused_speed_lsbs = ^{m1_speed_in[1:0], m2_speed_in[1:0]};

    // Frame sequencer: all outputs are registered and change with the state.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= ST_IDLE;
            hold_cnt        <= '0;
            byte_out        <= SYNC_BYTE;
            byte_strobe_out <= 1'b0;
            frame_done_out  <= 1'b0;
            cmd_ready_out   <= 1'b0;
            p1_q            <= 8'h00;
            p2_q            <= 8'h00;
            cs_q            <= 8'h00;
        end else begin
            byte_strobe_out <= 1'b0;
            frame_done_out  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    byte_out <= SYNC_BYTE;
                    if (transfer) begin
                        // Latch the whole command; inputs are free to change afterwards.
                        p1_q            <= p1_in;
                        p2_q            <= p2_in;
                        cs_q            <= p1_in ^ p2_in;
                        state           <= ST_HDR;
                        hold_cnt        <= HOLD_LOAD;
                        byte_strobe_out <= 1'b1;
                        cmd_ready_out   <= 1'b0;
                    end else begin
                        cmd_ready_out <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (last_cycle) begin
                        state           <= ST_M1;
                        byte_out        <= p1_q;
                        byte_strobe_out <= 1'b1;
                        hold_cnt        <= HOLD_LOAD;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_ONE;
                    end
                end
                ST_M1: begin
                    if (last_cycle) begin
                        state           <= ST_M2;
                        byte_out        <= p2_q;
                        byte_strobe_out <= 1'b1;
                        hold_cnt        <= HOLD_LOAD;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_ONE;
                    end
                end
                ST_M2: begin
                    if (last_cycle) begin
                        state           <= ST_CS;
                        byte_out        <= cs_q;
                        byte_strobe_out <= 1'b1;
                        hold_cnt        <= HOLD_LOAD;
                        // A one-cycle checksum byte is also its own last cycle.
                        frame_done_out  <= (HOLD_CYCLES == 1);
                    end else begin
                        hold_cnt <= hold_cnt - CNT_ONE;
                    end
                end
                ST_CS: begin
                    if (last_cycle) begin
                        byte_out <= SYNC_BYTE;
                        if (GAP_CYCLES == 0) begin
                            state         <= ST_IDLE;
                            cmd_ready_out <= 1'b1;
                        end else begin
                            state    <= ST_GAP;
                            hold_cnt <= GAP_LOAD;
                        end
                    end else begin
                        hold_cnt       <= hold_cnt - CNT_ONE;
                        // Raise done so it coincides with the final checksum cycle.
                        frame_done_out <= (hold_cnt == CNT_ONE);
                    end
                end
                ST_GAP: begin
                    byte_out <= SYNC_BYTE;
                    if (last_cycle) begin
                        state         <= ST_IDLE;
                        cmd_ready_out <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_ONE;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    byte_out      <= SYNC_BYTE;
                    cmd_ready_out <= 1'b0;
                    hold_cnt      <= '0;
                end
            endcase
        end
    end

endmodule
